lap_register_ctrl: RTL

LAP_REGISTER_CTRL -- requirements
Module: lap_register_ctrl

---
 rtl/lap_register_ctrl_pkg.sv | 30 +++
 rtl/lap_register_ctrl_ram.sv | 31 +++
 rtl/lap_register_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/lap_register_ctrl_pkg.sv
// Shared definitions for the lap register: field widths, default depth,
// control FSM state encoding and the stored entry layout.
package lap_register_ctrl_pkg;

    localparam int EPOCH_W       = 18;
    localparam int M_EPOCH_W     = 10;
    localparam int ENTRY_W       = EPOCH_W + M_EPOCH_W;
    localparam int DEPTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_WIPE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [EPOCH_W-1:0]   epoch;
        logic [M_EPOCH_W-1:0] m_epoch;
    } lap_entry_t;

    function automatic lap_entry_t pack_entry(input logic [EPOCH_W-1:0]   epoch,
                                              input logic [M_EPOCH_W-1:0] m_epoch);
        lap_entry_t e;
        e.epoch   = epoch;
        e.m_epoch = m_epoch;
        return e;
    endfunction

endpackage

// File: rtl/lap_register_ctrl_ram.sv
// Lap storage: DEPTH x 28-bit register array with one synchronous write
// port and one registered read port. Contents are not reset; the control
// logic never reads a slot that has not been written since the last clear.
module lap_ram
    import lap_register_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  lap_entry_t       wdata,
    input  logic [PTR_W-1:0] raddr,
    output lap_entry_t       rdata
);

    lap_entry_t mem_q [DEPTH];
    lap_entry_t rdata_q;

    // Write port and registered read port share the single clock.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lap_register_ctrl.sv
// Lap register controller: records timestamps on save, replays them
// oldest-to-newest on retrieve, and wipes the store on clear.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a command; only state that accepts pulses
// ST_WRITE | writing captured timestamp at wr_ptr, updating pointers/count
// ST_READ  | ram output for the cursor slot is valid; latch to lap outputs
// ST_WIPE  | zeroing one slot per cycle, down-counter from DEPTH-1 to 0
module lap_register_ctrl
    import lap_register_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       save,
    input  logic                       retrieve,
    input  logic                       clear,
    input  logic [EPOCH_W-1:0]         epoch,
    input  logic [M_EPOCH_W-1:0]       m_epoch,
    output logic                       busy,
    output logic [EPOCH_W-1:0]         lap_epoch,
    output logic [M_EPOCH_W-1:0]       lap_m_epoch,
    output logic                       lap_valid,
    output logic [$clog2(DEPTH)-1:0]   lap_index,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    state_e             state_q,     state_d;
    logic [PTR_W-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]   oldest_q,    oldest_d;
    logic [PTR_W-1:0]   cursor_q,    cursor_d;
    logic [PTR_W-1:0]   wipe_cnt_q,  wipe_cnt_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    lap_entry_t         cap_entry_q, cap_entry_d;
    lap_entry_t         lap_entry_q, lap_entry_d;
    logic [PTR_W-1:0]   lap_index_q, lap_index_d;
    logic               lap_valid_q, lap_valid_d;

    logic               reg_busy;
    logic               is_full;
    logic               ram_we;
    logic [PTR_W-1:0]   ram_waddr;
    lap_entry_t         ram_wdata;
    logic [PTR_W-1:0]   ram_raddr;
    lap_entry_t         ram_rdata;
    logic               cursor_at_newest;

    assign reg_busy = (state_q != ST_IDLE);
    assign is_full  = (count_q == CNT_W'(DEPTH));

    // The read address is issued every cycle so that the slot selected by
    // the cursor in IDLE is already registered by the time READ runs.
    assign ram_raddr        = oldest_q + cursor_q;
    assign cursor_at_newest = ({1'b0, cursor_q} == (count_q - CNT_W'(1)));

    lap_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_lap_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Next-state, datapath updates and storage write control.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        oldest_d    = oldest_q;
        cursor_d    = cursor_q;
        wipe_cnt_d  = wipe_cnt_q;
        count_d     = count_q;
        cap_entry_d = cap_entry_q;
        lap_entry_d = lap_entry_q;
        lap_index_d = lap_index_q;
        lap_valid_d = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = wr_ptr_q;
        ram_wdata   = cap_entry_q;

        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    wipe_cnt_d = PTR_W'(DEPTH - 1);
                    state_d    = ST_WIPE;
                end else if (save) begin
                    cap_entry_d = pack_entry(epoch, m_epoch);
                    state_d     = ST_WRITE;
                end else if (retrieve && (count_q != '0)) begin
                    state_d = ST_READ;
                end
            end

            ST_WRITE: begin
                ram_we    = 1'b1;
                ram_waddr = wr_ptr_q;
                ram_wdata = cap_entry_q;
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                // When full, the slot just overwritten was the oldest one.
                if (is_full) begin
                    oldest_d = oldest_q + PTR_W'(1);
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
                cursor_d = '0;
                state_d  = ST_IDLE;
            end

            ST_READ: begin
                lap_entry_d = ram_rdata;
                lap_index_d = cursor_q;
                lap_valid_d = 1'b1;
                cursor_d    = cursor_at_newest ? '0 : (cursor_q + PTR_W'(1));
                state_d     = ST_IDLE;
            end

            ST_WIPE: begin
                ram_we    = 1'b1;
                ram_waddr = wipe_cnt_q;
                ram_wdata = '0;
                if (wipe_cnt_q == '0) begin
                    count_d     = '0;
                    wr_ptr_d    = '0;
                    oldest_d    = '0;
                    cursor_d    = '0;
                    lap_entry_d = '0;
                    lap_index_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    wipe_cnt_d = wipe_cnt_q - PTR_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            oldest_q    <= '0;
            cursor_q    <= '0;
            wipe_cnt_q  <= '0;
            count_q     <= '0;
            cap_entry_q <= '0;
            lap_entry_q <= '0;
            lap_index_q <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            oldest_q    <= oldest_d;
            cursor_q    <= cursor_d;
            wipe_cnt_q  <= wipe_cnt_d;
            count_q     <= count_d;
            cap_entry_q <= cap_entry_d;
            lap_entry_q <= lap_entry_d;
            lap_index_q <= lap_index_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign busy        = reg_busy;
    assign lap_epoch   = lap_entry_q.epoch;
    assign lap_m_epoch = lap_entry_q.m_epoch;
    assign lap_valid   = lap_valid_q;
    assign lap_index   = lap_index_q;
    assign count       = count_q;
    assign full        = is_full;
    assign empty       = (count_q == '0);

endmodule
